// File: rtl/packed_lane_assembler.sv
// Assembles a stream of WB-bit elements into one WA x WB packed word with valid/ready on both sides.
// Optional whole-word replication is enabled by defining PACKED_LANE_ASM_REPLICATE_EN.
module packed_lane_assembler #(
    parameter int             WA         = 4,
    parameter int             WB         = 4,
    parameter bit             LANE_ORDER = 1'b0,
    parameter logic [WB-1:0]  FILL       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WB-1:0]              in_data,
    input  logic                       in_last,
    input  logic                       in_rep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WA*WB-1:0]           out_data,
    output logic [$clog2(WA+1)-1:0]    out_count
);

    localparam int IW = $clog2(WA);
    localparam int CW = $clog2(WA+1);

    localparam logic [WA-1:0][WB-1:0] FILL_WORD = {WA{FILL}};
    localparam logic [IW-1:0]         IDX_LAST  = IW'(WA-1);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           count_q, count_d;
    logic [WA-1:0][WB-1:0]   data_q, data_d;

    logic                    accept;
    logic                    rep_hit;
    logic [IW-1:0]           lane;

    assign in_ready  = (state_q == S_FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign lane      = LANE_ORDER ? idx_q : (IDX_LAST - idx_q);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign out_count = count_q;

`ifdef PACKED_LANE_ASM_REPLICATE_EN
    // Replication only counts as such on the first element of a word.
    assign rep_hit = in_rep && (idx_q == '0);
`else
    logic unused_rep;
    assign unused_rep = in_rep;
    assign rep_hit    = 1'b0;
`endif

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (rep_hit) begin
                        data_d  = {WA{in_data}};
                        count_d = CW'(WA);
                        state_d = S_HOLD;
                    end else begin
                        data_d[lane] = in_data;
                        count_d      = count_q + 1'b1;
                        // idx stays put on the closing element; the handshake clears it.
                        if (in_last || (idx_q == IDX_LAST)) begin
                            state_d = S_HOLD;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_FILL;
                    idx_d   = '0;
                    count_d = '0;
                    data_d  = FILL_WORD;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the word register is
    // reset too because untouched lanes must read as FILL right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            idx_q   <= '0;
            count_q <= '0;
            data_q  <= FILL_WORD;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_packed_lane_assembler.sv
// Scoreboard bench: two assemblers (big-endian FILL=D, little-endian FILL=0) share one stream.
// Define PACKED_LANE_ASM_REPLICATE_EN to check the replicate feature.
module tb_packed_lane_assembler;

    localparam int WA = 4;
    localparam int WB = 4;
    localparam int W  = WA * WB;
    localparam int CW = $clog2(WA + 1);
    localparam logic [WB-1:0] FILL_A = 4'hD;
    localparam logic [WB-1:0] FILL_B = 4'h0;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk, rst;
    logic          in_valid, in_last, in_rep, out_ready;
    logic [WB-1:0] in_data;
    logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [W-1:0]  out_data_a, out_data_b;
    logic [CW-1:0] out_count_a, out_count_b;

    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [WB-1:0] wbuf [WA];

    packed_lane_assembler #(.WA(WA), .WB(WB), .LANE_ORDER(1'b0), .FILL(FILL_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .in_last(in_last), .in_rep(in_rep), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_count(out_count_a));

    packed_lane_assembler #(.WA(WA), .WB(WB), .LANE_ORDER(1'b1), .FILL(FILL_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_last(in_last), .in_rep(in_rep), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_count(out_count_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: element j of a word lands at lane j (little-endian) or lane WA-1-j (big-endian).
    function automatic exp_t model(input logic [WB-1:0] els[$], input bit rep, input bit lsb_first,
                                   input logic [WB-1:0] fill);
        logic [WB-1:0] lanes [WA];
        exp_t r;
        for (int k = 0; k < WA; k++) lanes[k] = fill;
        if (rep) begin
            for (int k = 0; k < WA; k++) lanes[k] = els[0];
            r.count = CW'(WA);
        end else begin
            for (int j = 0; j < els.size(); j++) lanes[lsb_first ? j : WA - 1 - j] = els[j];
            r.count = CW'(els.size());
        end
        for (int k = 0; k < WA; k++) r.data[k*WB +: WB] = lanes[k];
        return r;
    endfunction

    // Consumer: random ready only in mode 2; directed code drives out_ready itself otherwise.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) out_ready = ($urandom_range(2, 0) != 0);
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready_match", in_ready_b, in_ready_a);
                check("out_valid_match", out_valid_b, out_valid_a);
                if (out_valid_a && out_ready) begin
                    if (qa.size() == 0 || qb.size() == 0) begin
                        check("unexpected_word", 1, 0);
                    end else begin
                        e = qa.pop_front();
                        check("word_a_data", out_data_a, e.data);
                        check("word_a_count", out_count_a, e.count);
                        e = qb.pop_front();
                        check("word_b_data", out_data_b, e.data);
                        check("word_b_count", out_count_b, e.count);
                    end
                end
            end
        end
    end

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready_a) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Sends wbuf[0..len-1]; stops early when the word closes, then queues the expected word.
    task automatic send_word(input int len, input bit rep0, input bit last_full, input int gap_max);
        logic [WB-1:0] els[$];
        bit done, ok, rep_hit;
        done = 1'b0;
        for (int j = 0; j < len && !done; j++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = wbuf[j];
            in_rep   = (j == 0) ? rep0 : 1'($urandom_range(1, 0));
            in_last  = (j == len - 1) && (len < WA || last_full);
            wait_accept(ok);
            if (!ok) begin
                check("accept_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
            els.push_back(wbuf[j]);
`ifdef PACKED_LANE_ASM_REPLICATE_EN
            rep_hit = (j == 0) && rep0;
`else
            rep_hit = 1'b0;
`endif
            done = in_last || (j == WA - 1) || rep_hit;
            in_valid = 1'b0;
            check("valid_after_accept", out_valid_a, done);
            if (done) begin
                qa.push_back(model(els, rep_hit, 1'b0, FILL_A));
                qb.push_back(model(els, rep_hit, 1'b1, FILL_B));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_rep   = 1'b0;
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, {out_valid_a, out_valid_b}, 2'b00);
        check({name, "_count"}, {out_count_a, out_count_b}, '0);
        check({name, "_data_a"}, out_data_a, {WA{FILL_A}});
        check({name, "_data_b"}, out_data_b, {WA{FILL_B}});
    endtask

    task automatic load(input logic [WB-1:0] e0, input logic [WB-1:0] e1,
                        input logic [WB-1:0] e2, input logic [WB-1:0] e3);
        wbuf[0] = e0; wbuf[1] = e1; wbuf[2] = e2; wbuf[3] = e3;
    endtask

    initial begin
        logic [W-1:0] held;
        bit ok;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_rep = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_in_ready", in_ready_a, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", in_ready_a, 1'b1);

        // Full big/little-endian word, then backpressure with in_valid held high.
        load(4'h3, 4'h2, 4'h1, 4'h0);
        send_word(4, 1'b0, 1'b0, 0);
        check("full_a", out_data_a, 16'h3210);
        check("full_b", out_data_b, 16'h0123);
        check("full_count", out_count_a, 3'd4);
        held = out_data_a;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = WB'($urandom);
            @(negedge clk);
            check("bp_in_ready", in_ready_a, 1'b0);
            check("bp_valid", out_valid_a, 1'b1);
            check("bp_stable", out_data_a, held);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        release_word();
        check_idle("after_handshake");
        check("in_ready_after_handshake", in_ready_a, 1'b1);

        // Single element closed by in_last.
        load(4'hF, 4'h0, 4'h0, 4'h0);
        send_word(1, 1'b0, 1'b0, 0);
        check("last_first_a", out_data_a, 16'hFDDD);
        check("last_first_b", out_data_b, 16'h000F);
        check("last_first_count", out_count_a, 3'd1);
        release_word();

        // Replicate request on the first element.
        load(4'h3, 4'h1, 4'h2, 4'h0);
        send_word(4, 1'b1, 1'b0, 0);
`ifdef PACKED_LANE_ASM_REPLICATE_EN
        check("rep_a", out_data_a, 16'h3333);
        check("rep_b", out_data_b, 16'h3333);
`else
        check("rep_a", out_data_a, 16'h3120);
        check("rep_b", out_data_b, 16'h0213);
`endif
        check("rep_count", out_count_a, 3'd4);
        release_word();

        // Reset after two accepts: partial word is discarded.
        in_rep = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h5;
        wait_accept(ok);
        in_data = 4'h6;
        wait_accept(ok);
        in_valid = 1'b0;
        check("partial_no_valid", out_valid_a, 1'b0);
        rst = 1'b1;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        load(4'h3, 4'h2, 4'h1, 4'h0);
        send_word(4, 1'b0, 1'b0, 0);
        check("post_reset_a", out_data_a, 16'h3210);
        release_word();

        // Randomised traffic with random consumer backpressure.
        rdy_mode = 2;
        for (int w = 0; w < 60; w++) begin
            for (int k = 0; k < WA; k++) wbuf[k] = WB'($urandom);
            send_word($urandom_range(WA, 1), ($urandom_range(3, 0) == 0),
                      1'($urandom_range(1, 0)), 2);
        end

        rdy_mode = 0;
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && qa.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
